// File: rtl/rvv_vd_writeback_if.sv
// Register-file write port bundle for the vector destination writeback.
// The master drives the request, the slave returns ready.
interface rvv_vd_writeback_if #(
    parameter int VLEN = 128
) ();
    logic            wr_valid;
    logic [4:0]      wr_addr;
    logic [VLEN-1:0] wr_data;
    logic            wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/rvv_vd_writeback.sv
// Collects lane result chunks into a vd image and writes it back once.
// Applies SEW packing, v0 masking, tail and reduction rules.
module rvv_vd_writeback #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [4:0]                    vd_addr,
    input  logic [VLEN-1:0]               vd_old,
    input  logic [VLEN-1:0]               v0_mask,
    input  logic                          mask_en,
    input  logic                          reduce,
    input  logic [2:0]                    vsew,
    input  logic [16:0]                   vl,
    input  logic [64*(1<<NB_LANES)-1:0]   lane_data,
    input  logic [17*(1<<NB_LANES)-1:0]   lane_idx,
    input  logic [3:0]                    lane_off,
    input  logic [(1<<NB_LANES)-1:0]      lane_valid,
    input  logic                          alu_done,
    output logic                          busy,
    rvv_vd_writeback_if.master            wr,
    output logic                          wb_done,
    output logic                          oob_err
);
    localparam int L  = 1 << NB_LANES;
    localparam int LW = 1 << LANE_WIDTH;
    localparam int IW = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t          state_q, state_d;
    logic [VLEN-1:0] buf_q, v0_q;
    logic [4:0]      addr_q;
    logic            mask_en_q, reduce_q;
    logic [2:0]      vsew_q;
    logic [16:0]     vl_q;

    logic [31:0]     sew, w, pos;
    logic [16:0]     e_idx;
    logic [63:0]     lowm;
    logic [VLEN-1:0] wm, dv, nb;
    logic            take, mbit, oob_hit;

    // Lanes are merged in ascending order so the highest lane wins overlaps.
    always_comb begin
        sew     = 32'd8 << vsew_q;
        nb      = buf_q;
        oob_hit = 1'b0;
        e_idx   = '0;
        w       = '0;
        pos     = '0;
        lowm    = '0;
        wm      = '0;
        dv      = '0;
        take    = 1'b0;
        mbit    = 1'b0;
        for (int i = 0; i < L; i++) begin
            take  = lane_valid[i] && (!reduce_q || i == 0);
            e_idx = reduce_q ? 17'd0 : lane_idx[i*17 +: 17];
            w     = reduce_q ? sew : ((sew < 32'(LW)) ? sew : 32'(LW));
            pos   = 32'(e_idx) * sew;
            if (!reduce_q && sew > 32'(LW))
                pos = pos + 32'(lane_off) * w;
            mbit = (32'(e_idx) < 32'(VLEN)) && v0_q[e_idx[IW-1:0]];
            if (e_idx >= vl_q)
                take = 1'b0;
            if (mask_en_q && !mbit)
                take = 1'b0;
            lowm = (w >= 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
            if (take && (pos + w > 32'(VLEN))) begin
                oob_hit = 1'b1;
                take    = 1'b0;
            end
            if (take) begin
                wm       = '0;
                wm[63:0] = lowm;
                wm       = wm << pos;
                dv       = '0;
                dv[63:0] = lane_data[i*64 +: 64] & lowm;
                dv       = dv << pos;
                nb       = (nb & ~wm) | (dv & wm);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = COLLECT;
            COLLECT: if (alu_done)    state_d = WRITE;
            WRITE:   if (wr.wr_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_q     <= '0;
            v0_q      <= '0;
            addr_q    <= '0;
            mask_en_q <= 1'b0;
            reduce_q  <= 1'b0;
            vsew_q    <= '0;
            vl_q      <= '0;
            wb_done   <= 1'b0;
            oob_err   <= 1'b0;
        end else begin
            wb_done <= (state_q == WRITE) && wr.wr_ready;
            if (state_q == IDLE && start) begin
                buf_q     <= vd_old;
                v0_q      <= v0_mask;
                addr_q    <= vd_addr;
                mask_en_q <= mask_en;
                reduce_q  <= reduce;
                vsew_q    <= vsew;
                vl_q      <= vl;
                oob_err   <= 1'b0;
            end else if (state_q == COLLECT) begin
                buf_q <= nb;
                if (oob_hit)
                    oob_err <= 1'b1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign wr.wr_valid = (state_q == WRITE);
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = buf_q;
endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Randomized and directed bench for rvv_vd_writeback with a bit-level model.
// Model keeps the expected vd image and applies chunks bit by bit.
module tb_rvv_vd_writeback;
    localparam int VLEN = 128;
    localparam int L    = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [4:0]      vd_addr;
    logic [VLEN-1:0] vd_old, v0_mask;
    logic            mask_en, reduce;
    logic [2:0]      vsew;
    logic [16:0]     vl;
    logic [64*L-1:0] lane_data;
    logic [17*L-1:0] lane_idx;
    logic [3:0]      lane_off;
    logic [L-1:0]    lane_valid;
    logic            alu_done;
    logic            busy, wb_done, oob_err;

    rvv_vd_writeback_if #(.VLEN(VLEN)) wr_if ();

    rvv_vd_writeback #(.VLEN(VLEN), .LANE_WIDTH(3), .NB_LANES(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr),
        .vd_old(vd_old), .v0_mask(v0_mask), .mask_en(mask_en),
        .reduce(reduce), .vsew(vsew), .vl(vl), .lane_data(lane_data),
        .lane_idx(lane_idx), .lane_off(lane_off), .lane_valid(lane_valid),
        .alu_done(alu_done), .busy(busy), .wr(wr_if), .wb_done(wb_done),
        .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [VLEN-1:0] m_img, m_v0;
    int              m_sew, m_vl;
    bit              m_men, m_red, m_oob;
    logic [4:0]      m_addr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VLEN-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Element-level reference: drop rules first, then bitwise placement.
    function automatic void model_chunk(int lane, int idx, int off, logic [63:0] d);
        int e, w, pos;
        if (m_red && lane != 0) return;
        e = m_red ? 0 : idx;
        if (e >= m_vl) return;
        if (m_men && (e >= VLEN || m_v0[e] == 1'b0)) return;
        w   = m_red ? m_sew : ((m_sew < 8) ? m_sew : 8);
        pos = e * m_sew + ((!m_red && m_sew > 8) ? off * w : 0);
        if (pos + w > VLEN) begin
            m_oob = 1'b1;
            return;
        end
        for (int b = 0; b < w; b++) m_img[pos+b] = d[b];
    endfunction

    task automatic begin_instr(input logic [4:0] a, input logic [VLEN-1:0] old,
                               input logic [VLEN-1:0] v0, input bit men,
                               input bit red, input int code, input int vlen);
        vd_addr = a; vd_old = old; v0_mask = v0; mask_en = men;
        reduce = red; vsew = 3'(code); vl = 17'(vlen); start = 1'b1;
        m_img = old; m_v0 = v0; m_men = men; m_red = red;
        m_sew = 8 << code; m_vl = vlen; m_oob = 1'b0; m_addr = a;
        tick;
        start = 1'b0;
    endtask

    task automatic drive(input logic [1:0] v, input int i0, input logic [63:0] d0,
                         input int i1, input logic [63:0] d1, input int off,
                         input bit done);
        lane_valid = v;
        lane_idx   = {17'(i1), 17'(i0)};
        lane_data  = {d1, d0};
        lane_off   = 4'(off);
        alu_done   = done;
        if (v[0]) model_chunk(0, i0, off, d0);
        if (v[1]) model_chunk(1, i1, off, d1);
        tick;
        lane_valid = '0;
        alu_done   = 1'b0;
    endtask

    task automatic handshake;
        wr_if.wr_ready = 1'b1;
        tick;
        wr_if.wr_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 0; vd_addr = 0; vd_old = 0; v0_mask = 0;
        mask_en = 0; reduce = 0; vsew = 0; vl = 0; lane_data = 0;
        lane_idx = 0; lane_off = 0; lane_valid = 0; alu_done = 0;
        wr_if.wr_ready = 1'b0;
        tick; tick;
        checks++;
        if ({busy, wr_if.wr_valid, wb_done, oob_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy, wr_if.wr_valid, wb_done, oob_err});
        end
        checks++;
        if (wr_if.wr_addr !== 5'd0 || wr_if.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0", wr_if.wr_addr, wr_if.wr_data);
        end
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_sew8_fill;
        begin_instr(5'd3, '1, '0, 0, 0, 0, 16);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL fill_busy got %b want 1", busy);
        end
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 2*k, 64'(2*k), 2*k+1, 64'(2*k+1), 0, k == 7);
            if (k == 6) begin
                checks++;
                if (wr_if.wr_valid !== 1'b0) begin
                    errors++; $display("FAIL fill_early_valid got %b want 0", wr_if.wr_valid);
                end
            end
        end
        checks++;
        if (wr_if.wr_valid !== 1'b1) begin
            errors++; $display("FAIL fill_latency got %b want 1", wr_if.wr_valid);
        end
        checks++;
        if (wr_if.wr_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            errors++; $display("FAIL fill_data got %h want 0f0e..00", wr_if.wr_data);
        end
        checks++;
        if (wr_if.wr_addr !== 5'd3) begin
            errors++; $display("FAIL fill_addr got %0d want 3", wr_if.wr_addr);
        end
        handshake;
        checks++;
        if ({wb_done, busy, wr_if.wr_valid} !== 3'b100) begin
            errors++; $display("FAIL fill_done got %b want 100", {wb_done, busy, wr_if.wr_valid});
        end
        tick;
        checks++;
        if (wb_done !== 1'b0) begin
            errors++; $display("FAIL fill_done_pulse got %b want 0", wb_done);
        end
    endtask

    task automatic test_sew32_chunks;
        logic [VLEN-1:0] old;
        logic [63:0]     dv [4];
        old = 128'h0123456789ABCDEF_FEDCBA9876543210;
        dv[0] = 64'hDD; dv[1] = 64'hCC; dv[2] = 64'hBB; dv[3] = 64'hAA;
        begin_instr(5'd4, old, '0, 0, 0, 2, 4);
        for (int k = 0; k < 4; k++) drive(2'b01, 1, dv[k], 0, 0, k, k == 3);
        checks++;
        if (wr_if.wr_data !== 128'h0123456789ABCDEF_AABBCCDD76543210) begin
            errors++; $display("FAIL sew32_data got %h want ..aabbccdd..", wr_if.wr_data);
        end
        handshake;
    endtask

    task automatic test_mask;
        begin_instr(5'd5, '0, 128'h5555, 1, 0, 0, 16);
        for (int k = 0; k < 8; k++)
            drive(2'b11, 2*k, 64'h11, 2*k+1, 64'h11, 0, k == 7);
        checks++;
        if (wr_if.wr_data !== {8{16'h0011}}) begin
            errors++; $display("FAIL mask_data got %h want 0011 x8", wr_if.wr_data);
        end
        handshake;
    endtask

    task automatic test_tail_oob;
        begin_instr(5'd6, '0, '0, 0, 0, 1, 5);
        for (int off = 0; off < 2; off++)
            for (int k = 0; k < 4; k++)
                drive(2'b11, 2*k, off == 0 ? 64'hEF : 64'hBE,
                      2*k+1, off == 0 ? 64'hEF : 64'hBE, off, off == 1 && k == 3);
        checks++;
        if (wr_if.wr_data !== 128'h000000000000_BEEFBEEFBEEFBEEFBEEF) begin
            errors++; $display("FAIL tail_data got %h want 5x beef", wr_if.wr_data);
        end
        checks++;
        if (oob_err !== 1'b0) begin
            errors++; $display("FAIL tail_oob got %b want 0", oob_err);
        end
        handshake;
        begin_instr(5'd6, '0, '0, 0, 0, 1, 16);
        drive(2'b01, 9, 64'h77, 0, 0, 0, 0);
        checks++;
        if (oob_err !== 1'b1) begin
            errors++; $display("FAIL oob_flag got %b want 1", oob_err);
        end
        drive(2'b00, 0, 0, 0, 0, 0, 1);
        checks++;
        if (wr_if.wr_data !== '0) begin
            errors++; $display("FAIL oob_data got %h want 0", wr_if.wr_data);
        end
        handshake;
    endtask

    task automatic test_reduce;
        begin_instr(5'd8, '0, '0, 0, 1, 1, 8);
        checks++;
        if (oob_err !== 1'b0) begin
            errors++; $display("FAIL oob_clear got %b want 0", oob_err);
        end
        drive(2'b11, 3, 64'h1234, 5, 64'h5678, 0, 1);
        checks++;
        if (wr_if.wr_data !== 128'h1234) begin
            errors++; $display("FAIL reduce_data got %h want 1234", wr_if.wr_data);
        end
        handshake;
    endtask

    task automatic test_back_to_back;
        logic [VLEN-1:0] old;
        old = rand128();
        alu_done = 1'b1;
        begin_instr(5'd9, old, '1, 0, 0, 0, 0);
        checks++;
        if ({busy, wr_if.wr_valid} !== 2'b10) begin
            errors++; $display("FAIL start_done got %b want 10", {busy, wr_if.wr_valid});
        end
        drive(2'b11, 0, 64'h12, 1, 64'h34, 0, 1);
        checks++;
        if (wr_if.wr_data !== old) begin
            errors++; $display("FAIL vl0_data got %h want %h", wr_if.wr_data, old);
        end
        handshake;
        begin_instr(5'd10, '0, '0, 0, 0, 0, 16);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL restart_busy got %b want 1", busy);
        end
        drive(2'b01, 15, 64'h9A, 0, 0, 0, 1);
        checks++;
        if (wr_if.wr_data !== m_img || wr_if.wr_addr !== 5'd10) begin
            errors++; $display("FAIL restart_data got %h want %h", wr_if.wr_data, m_img);
        end
        handshake;
    endtask

    task automatic test_random;
        int code, sew, ncyc, dly;
        for (int n = 0; n < 30; n++) begin
            code = $urandom_range(0, 3);
            sew  = 8 << code;
            begin_instr(5'($urandom), rand128(), rand128(), bit'($urandom_range(0, 1)),
                        $urandom_range(0, 7) == 0, code,
                        $urandom_range(0, VLEN / sew + 1));
            checks++;
            if (oob_err !== 1'b0) begin
                errors++; $display("FAIL rnd_oob_clear n=%0d got %b want 0", n, oob_err);
            end
            ncyc = $urandom_range(1, 6);
            for (int c = 0; c < ncyc; c++)
                drive(2'($urandom), $urandom_range(0, VLEN / sew + 3), {$urandom, $urandom},
                      $urandom_range(0, VLEN / sew + 3), {$urandom, $urandom},
                      $urandom_range(0, 8), c == ncyc - 1);
            dly = $urandom_range(0, 3);
            for (int c = 0; c < dly; c++) tick;
            checks++;
            if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== m_img) begin
                errors++;
                $display("FAIL rnd_data n=%0d v=%b got %h want %h", n,
                         wr_if.wr_valid, wr_if.wr_data, m_img);
            end
            checks++;
            if (wr_if.wr_addr !== m_addr || oob_err !== m_oob) begin
                errors++;
                $display("FAIL rnd_addr_oob n=%0d got %0d/%b want %0d/%b", n,
                         wr_if.wr_addr, oob_err, m_addr, m_oob);
            end
            handshake;
            checks++;
            if (wb_done !== 1'b1) begin
                errors++; $display("FAIL rnd_wb_done n=%0d got %b want 1", n, wb_done);
            end
        end
    endtask

    task automatic test_backpressure;
        begin_instr(5'd7, rand128(), '0, 0, 0, 0, 16);
        drive(2'b01, 0, 64'hA5, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; vd_addr = 5'd9; vd_old = ~m_img;
            lane_valid = 2'b11; lane_idx = {17'd1, 17'd0}; lane_data = '1;
            tick;
            checks++;
            if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== m_img ||
                wr_if.wr_addr !== 5'd7 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got %b %h %0d want 1 %h 7", c,
                         wr_if.wr_valid, wr_if.wr_data, wr_if.wr_addr, m_img);
            end
        end
        start = 1'b0; lane_valid = '0;
        resetn = 1'b0;
        tick;
        checks++;
        if ({wr_if.wr_valid, busy, wb_done} !== 3'b000 || wr_if.wr_data !== '0) begin
            errors++;
            $display("FAIL bp_reset got %b %h want 000 0",
                     {wr_if.wr_valid, busy, wb_done}, wr_if.wr_data);
        end
        resetn = 1'b1;
        wr_if.wr_ready = 1'b1;
        tick;
        wr_if.wr_ready = 1'b0;
        checks++;
        if ({wb_done, busy} !== 2'b00) begin
            errors++; $display("FAIL bp_no_done got %b want 00", {wb_done, busy});
        end
    endtask

    initial begin
        test_reset;
        test_sew8_fill;
        test_sew32_chunks;
        test_mask;
        test_tail_oob;
        test_reduce;
        test_back_to_back;
        test_random;
        test_backpressure;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvv_vd_writeback.md
Name: rvv_vd_writeback

Overview:
- Receiving end of the vector ALU lane-result interface: collects per-lane result chunks (data, element index, lane-valid) across the cycles of one vector instruction.
- Merges chunks into a VLEN-bit destination image seeded with the old vd value, applying SEW packing, v0 masking and tail rules.
- Issues one valid/ready write to the vector register file when the ALU signals done.
- Sits between the lane ALU wrapper and the vector register file write port.

Parameters:
VLEN, 128, vector register width in bits (power of two, 64..1024).
LANE_WIDTH, 3, log2 of lane chunk width in bits (chunk width LW = 1<<LANE_WIDTH).
NB_LANES, 1, log2 of lane count (L = 1<<NB_LANES).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: begin a new instruction, latch config
vd_addr  in  5  destination register index, latched on start
vd_old  in  VLEN  previous vd contents, latched on start as buffer seed
v0_mask  in  VLEN  mask register, latched on start
mask_en  in  1  1 = masked op (vm=0), latched on start
reduce  in  1  1 = reduction op: only lane 0 / element 0 accepted, latched on start
vsew  in  3  SEW code (SEW = 8<<vsew), latched on start
vl  in  17  active vector length, latched on start
lane_data  in  64*L  per-lane result, low W bits used
lane_idx  in  17*L  per-lane element index
lane_off  in  4  chunk offset within element (shared by all lanes)
lane_valid  in  L  per-lane result valid this cycle
alu_done  in  1  last lane results of the instruction present this cycle
busy  out  1  high from accepted start until write handshake completes
wr_valid  out  1  register-file write request
wr_addr  out  5  register index for write
wr_data  out  VLEN  merged destination image
wr_ready  in  1  register file accepts write
wb_done  out  1  one-cycle pulse on write handshake
oob_err  out  1  sticky: a chunk addressed beyond VLEN was dropped; cleared on start

Behaviour:
- Reset: state IDLE, busy=0, wr_valid=0, wb_done=0, oob_err=0, wr_addr=0, buffer=0; applies mid-operation, aborting any pending write without handshake.
- States: IDLE, COLLECT, WRITE.
- IDLE:
  - start=1 latches all config, loads buffer<=vd_old, clears oob_err, goes to COLLECT; busy=1 from the next cycle.
  - lane_valid and alu_done are ignored.
- COLLECT: each cycle, for each lane i with lane_valid[i]=1, compute:
  - W = min(SEW, LW)
  - pos = idx*SEW + (SEW>LW ? lane_off*W : 0)
  - chunk = lane_data[W-1:0]
- Chunk drop rules:
  - idx >= vl (tail): dropped silently; tail keeps vd_old.
  - mask_en=1 and v0_mask[idx]=0: dropped; element stays undisturbed.
  - reduce=1: only lane 0 accepted, forced to idx 0 with width SEW; other lanes ignored.
  - pos+W > VLEN: dropped, oob_err<=1.
- Otherwise buffer[pos +: W] <= chunk.
- Multiple lanes hitting the same bits in one cycle: the highest-numbered lane wins.
- A later cycle overwrites an earlier one.
- alu_done=1 in COLLECT: that cycle's lane results are merged, then go to WRITE.
  - wr_valid=1 from the next cycle.
  - Minimum latency: alu_done cycle to wr_valid = 1 cycle.
- WRITE:
  - wr_valid=1, wr_data=buffer, wr_addr=latched vd_addr, all held stable until wr_ready.
  - On wr_valid&&wr_ready: next cycle wr_valid=0, busy=0, wb_done=1 for one cycle, state IDLE.
  - lane inputs ignored.
- start while not IDLE: ignored (no re-latch).
- start in the cycle wb_done is high: accepted, since state is IDLE.
- vl=0: no chunks accepted; alu_done still produces a write of vd_old unchanged.
- alu_done together with start in IDLE: start is accepted, alu_done is ignored.
- Index arithmetic is at least 27 bits wide so that idx*SEW cannot wrap.

Test Plan:
1. VLEN=128, L=2, SEW=8, vl=16, no mask, vd_old=all 0xFF. Lanes deliver idx 2k/2k+1 with data=idx over 8 cycles, alu_done on the last -> wr_data bytes = 0x0F..0x00; wr_valid 1 cycle after alu_done; wb_done after wr_ready.
2. SEW=32, LW=8: element 1 delivered as 4 chunks at lane_off 0..3 (0xDD,0xCC,0xBB,0xAA) -> wr_data[63:32]=0xAABBCCDD; other words = vd_old.
3. mask_en=1, v0_mask=0x5555, SEW=8, vl=16, lanes write 0x11 everywhere, vd_old=0 -> wr_data = 0x0011 repeated per byte pair (even bytes 0x11, odd bytes 0x00).
4. vl=5, SEW=16: chunks for idx 0..7 with data 0xBEEF, vd_old=0 -> halfwords 0..4 = 0xBEEF, halfwords 5..7 = 0; oob_err=0. Separately, idx 9 at SEW=16 -> dropped, oob_err=1.
5. reduce=1: lane 0 data 0x1234 idx 3, lane 1 valid -> only element 0 = 0x1234 (SEW=16).
6. Backpressure: wr_ready low for 5 cycles -> wr_valid/wr_data stable and extra start ignored. Then resetn low for one cycle in WRITE -> wr_valid=0, busy=0, no wb_done.
